// File: rtl/rv32i_types.sv
// Shared types and constants for the RV32I front end.
package rv32i_types;

    typedef enum logic [1:0] {
        REQ      = 2'd0,
        DISCARD  = 2'd1,
        WAIT_BUF = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0060;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// 32-bit load-enable register with a parameterised reset value.
module pc_reg #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, one-entry output
// buffer toward IF/ID, redirect handling with in-flight response discard.
module instr_fetch
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        ifid_flush
);

    fetch_state_t state_reg;

    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    logic [31:0] fetch_pc_next;
    logic [31:0] req_addr_next;
    logic        fetch_pc_load;
    logic        req_addr_load;
    logic [31:0] target_pc;
    logic [31:0] req_addr_plus4;
    logic        capture;
    logic        consume;

    assign target_pc      = align_pc(redirect_pc);
    assign req_addr_plus4 = req_addr + 32'd4;
    assign capture        = (state_reg == REQ) && imem_resp && !redirect;
    assign consume        = out_valid && !stall;

    assign imem_read    = !rst && (state_reg != WAIT_BUF);
    assign imem_address = req_addr;
    assign ifid_flush   = redirect;

    always_comb begin
        fetch_pc_load = 1'b0;
        fetch_pc_next = fetch_pc;
        req_addr_load = 1'b0;
        req_addr_next = req_addr;
        case (state_reg)
            REQ: begin
                if (redirect) begin
                    fetch_pc_load = 1'b1;
                    fetch_pc_next = target_pc;
                    // A response in the redirect cycle is dropped and the
                    // target can be requested straight away.
                    if (imem_resp) begin
                        req_addr_load = 1'b1;
                        req_addr_next = target_pc;
                    end
                end else if (imem_resp) begin
                    fetch_pc_load = 1'b1;
                    fetch_pc_next = req_addr_plus4;
                    if (consume) begin
                        req_addr_load = 1'b1;
                        req_addr_next = req_addr_plus4;
                    end
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fetch_pc_load = 1'b1;
                    fetch_pc_next = target_pc;
                end
                if (imem_resp) begin
                    req_addr_load = 1'b1;
                    req_addr_next = redirect ? target_pc : fetch_pc;
                end
            end
            WAIT_BUF: begin
                if (redirect) begin
                    fetch_pc_load = 1'b1;
                    fetch_pc_next = target_pc;
                    req_addr_load = 1'b1;
                    req_addr_next = target_pc;
                end else if (!stall) begin
                    req_addr_load = 1'b1;
                    req_addr_next = fetch_pc;
                end
            end
            default: begin
                fetch_pc_load = 1'b0;
            end
        endcase
    end

    pc_reg #(.RESET_VALUE(RESET_PC)) u_fetch_pc (
        .clk  (clk),
        .rst  (rst),
        .load (fetch_pc_load),
        .d    (fetch_pc_next),
        .q    (fetch_pc)
    );

    pc_reg #(.RESET_VALUE(RESET_PC)) u_req_addr (
        .clk  (clk),
        .rst  (rst),
        .load (req_addr_load),
        .d    (req_addr_next),
        .q    (req_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= REQ;
            out_valid    <= 1'b0;
            instr_out    <= 32'h0000_0000;
            pc_out       <= RESET_PC;
            pc_plus4_out <= RESET_PC + 32'd4;
        end else begin
            case (state_reg)
                REQ: begin
                    if (redirect) begin
                        state_reg <= imem_resp ? REQ : DISCARD;
                    end else if (imem_resp) begin
                        state_reg <= consume ? REQ : WAIT_BUF;
                    end
                end
                DISCARD: begin
                    if (imem_resp) begin
                        state_reg <= REQ;
                    end
                end
                WAIT_BUF: begin
                    if (redirect || !stall) begin
                        state_reg <= REQ;
                    end
                end
                default: state_reg <= REQ;
            endcase

            // Redirect flushes the buffer even while the stage is stalled.
            if (redirect) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid    <= 1'b1;
                instr_out    <= imem_rdata;
                pc_out       <= req_addr;
                pc_plus4_out <= req_addr_plus4;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
